// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the execute-stage ALU.
//   - XLEN: datapath width (only 32 is supported).
//   - OP_*: 5-bit ALU control codes produced by the ALU control decoder.
//   - MUL_BITS_*: legal multiplier bits retired per iteration.
//   - alu_state_e: top-level FSM encoding (exposed on the debug port).
//   - magnitude(): absolute value as an unsigned number (0x80000000 -> 2^31).
package alu_exec_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_ADD = 5'b00010;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_SLT = 5'b00111;
  localparam logic [4:0] OP_NOR = 5'b01100;
  localparam logic [4:0] OP_XOR = 5'b01101;
  localparam logic [4:0] OP_SLL = 5'b10000;
  localparam logic [4:0] OP_SRL = 5'b11000;
  localparam logic [4:0] OP_SRA = 5'b11001;
  localparam logic [4:0] OP_MUL = 5'b11111;

  localparam int MUL_BITS_1 = 1;
  localparam int MUL_BITS_2 = 2;
  localparam int MUL_BITS_4 = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL      = 2'd1,
    ST_MUL_DONE = 2'd2
  } alu_state_e;

  function automatic bit mul_bits_legal(input int bits);
    return (bits == MUL_BITS_1) || (bits == MUL_BITS_2) || (bits == MUL_BITS_4);
  endfunction

  // Two's-complement negate of the most negative value wraps to itself,
  // which read as unsigned is exactly 2^31 -- the correct magnitude.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between the pipeline (master) and the ALU (slave).
// Handshake: an issue is accepted at a rising edge where in_valid=1,
// in_ready=1 and flush=0; otherwise it is ignored and the pipeline holds
// the instruction (busy is the stall request while a multiply runs).
// out_valid is a one-cycle pulse; out/out_hi/zero hold between pulses.
interface alu_exec_unit_if;
  import alu_exec_unit_pkg::*;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      ALUCtl;
  logic            Sign;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            out_valid;
  logic [XLEN-1:0] out;
  logic [XLEN-1:0] out_hi;
  logic            zero;
  logic            busy;

  modport master (
    output flush, in_valid, ALUCtl, Sign, in1, in2,
    input  in_ready, out_valid, out, out_hi, zero, busy
  );

  modport slave (
    input  flush, in_valid, ALUCtl, Sign, in1, in2,
    output in_ready, out_valid, out, out_hi, zero, busy
  );

endinterface

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier.
//   clk, reset_n : clock, async active-low reset
//   flush        : abandon the running multiply
//   start        : capture a/b/sign and begin (one-cycle strobe)
//   sign         : 1 = signed operands, 0 = unsigned
//   a, b         : operands
//   done         : high during the edge that retires the last iteration
//   product      : 64-bit result, valid the cycle after done
module alu_iter_mul
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               start,
  input  logic               sign,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int ITERS = WIDTH / MUL_BITS;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  logic               running;
  logic               neg;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;

  // Retire MUL_BITS multiplier bits: add the correspondingly shifted
  // multiplicand for each set bit.
  always_comb begin
    acc_next = acc;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (mplier[i]) acc_next = acc_next + (mcand << i);
    end
  end

  assign done    = running && (cnt == '0);
  // Magnitudes were multiplied; restore the sign of the full 64-bit result.
  assign product = neg ? (~acc + 1'b1) : acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
      neg     <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
    end else if (flush) begin
      running <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= CNT_LAST;
      mcand   <= {{WIDTH{1'b0}}, magnitude(a, sign)};
      mplier  <= magnitude(b, sign);
      acc     <= '0;
      neg     <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (running) begin
      acc    <= acc_next;
      mcand  <= mcand << MUL_BITS;
      mplier <= mplier >> MUL_BITS;
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU.
//   clk, reset_n : pipeline clock, async active-low reset
//   bus          : issue/result bundle (slave side), see alu_exec_unit_if
//   state_dbg    : current FSM state
// Single-cycle ops register their result one edge after issue. MUL hands
// the operands to alu_iter_mul, holds busy while it iterates, then loads
// out/out_hi/zero in MUL_DONE.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_exec_unit_if.slave    bus,
  output alu_state_e        state_dbg
);

  // Unsupported step sizes fall back to one bit per iteration.
  localparam int MUL_STEP = mul_bits_legal(MUL_BITS) ? MUL_BITS : 1;

  alu_state_e         state;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   out_q;
  logic [WIDTH-1:0]   out_hi_q;
  logic               out_valid_q;
  logic               zero_q;
  logic               busy_q;
  logic               in_ready_q;
  logic               lt;
  logic [4:0]         shamt;
  logic               accept;
  logic               is_mul;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign shamt     = bus.in1[4:0];
  assign is_mul    = (bus.ALUCtl == OP_MUL);
  assign accept    = bus.in_valid && in_ready_q && !bus.flush;
  assign mul_start = accept && is_mul && (state == ST_IDLE);

  assign lt = bus.Sign ? ($signed(bus.in1) < $signed(bus.in2)) : (bus.in1 < bus.in2);

  // Single-cycle datapath; unknown codes behave as ADD.
  always_comb begin
    alu_res = bus.in1 + bus.in2;
    case (bus.ALUCtl)
      OP_AND:  alu_res = bus.in1 & bus.in2;
      OP_OR:   alu_res = bus.in1 | bus.in2;
      OP_ADD:  alu_res = bus.in1 + bus.in2;
      OP_SUB:  alu_res = bus.in1 - bus.in2;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt};
      OP_NOR:  alu_res = ~(bus.in1 | bus.in2);
      OP_XOR:  alu_res = bus.in1 ^ bus.in2;
      OP_SLL:  alu_res = bus.in2 << shamt;
      OP_SRL:  alu_res = bus.in2 >> shamt;
      OP_SRA:  alu_res = $signed(bus.in2) >>> shamt;
      default: alu_res = bus.in1 + bus.in2;
    endcase
  end

  alu_iter_mul #(
    .WIDTH    (WIDTH),
    .MUL_BITS (MUL_STEP)
  ) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (bus.flush),
    .start   (mul_start),
    .sign    (bus.Sign),
    .a       (bus.in1),
    .b       (bus.in2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      out_q       <= '0;
      out_hi_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.flush) begin
        // Kills whatever is in flight, including a pending MUL_DONE load.
        state      <= ST_IDLE;
        busy_q     <= 1'b0;
        in_ready_q <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              if (is_mul) begin
                state      <= ST_MUL;
                busy_q     <= 1'b1;
                in_ready_q <= 1'b0;
              end else begin
                out_q       <= alu_res;
                out_hi_q    <= '0;
                zero_q      <= (alu_res == '0);
                out_valid_q <= 1'b1;
              end
            end
          end
          ST_MUL: begin
            if (mul_done) state <= ST_MUL_DONE;
          end
          ST_MUL_DONE: begin
            out_q       <= mul_product[WIDTH-1:0];
            out_hi_q    <= mul_product[2*WIDTH-1:WIDTH];
            zero_q      <= (mul_product[WIDTH-1:0] == '0);
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_hi    = out_hi_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  localparam int MUL_BITS = 1;
  localparam int MUL_LAT  = 32 / MUL_BITS + 1;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n;
  alu_state_e state_dbg;

  alu_exec_unit_if bus();

  alu_exec_unit #(
    .WIDTH    (32),
    .MUL_BITS (MUL_BITS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_lo_last = 32'h0;
  logic [31:0] exp_hi_last = 32'h0;

  // ---------------- reference model ----------------
  // Computes the {hi, lo} result from the op definitions using 64-bit
  // integer arithmetic.
  function automatic logic [63:0] model(input logic [4:0] ctl, input logic sgn,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [31:0] lo;
    int          sh;
    sh = int'(a[4:0]);
    sa = sgn ? longint'($signed(a)) : longint'({32'h0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'h0, b});
    case (ctl)
      5'b00000: lo = a & b;
      5'b00001: lo = a | b;
      5'b00010: lo = a + b;
      5'b00110: lo = a - b;
      5'b00111: lo = (sa < sb) ? 32'd1 : 32'd0;
      5'b01100: lo = ~(a | b);
      5'b01101: lo = a ^ b;
      5'b10000: lo = b << sh;
      5'b11000: lo = b >> sh;
      5'b11001: lo = (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      5'b11111: return sa * sb;
      default:  lo = a + b;
    endcase
    return {32'h0, lo};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [4:0] ctl, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b);
    bus.ALUCtl   = ctl;
    bus.Sign     = sgn;
    bus.in1      = a;
    bus.in2      = b;
    bus.in_valid = 1'b1;
  endtask

  task automatic drive_idle();
    bus.in_valid = 1'b0;
  endtask

  // One single-cycle op: result must appear exactly one edge after issue.
  task automatic run_single(input logic [4:0] ctl, input logic sgn, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp, input string name);
    logic [31:0] lo;
    lo = exp[31:0];
    @(negedge clk);
    drive_op(ctl, sgn, a, b);
    @(negedge clk);
    drive_idle();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL %s valid: got %b expected 1", name, bus.out_valid);
    end
    checks++;
    if (bus.out !== lo) begin
      errors++; $display("FAIL %s out: got %h expected %h", name, bus.out, lo);
    end
    checks++;
    if (bus.out_hi !== 32'h0) begin
      errors++; $display("FAIL %s out_hi: got %h expected 0", name, bus.out_hi);
    end
    checks++;
    if (bus.zero !== (lo == 32'h0)) begin
      errors++; $display("FAIL %s zero: got %b expected %b", name, bus.zero, lo == 32'h0);
    end
    exp_lo_last = lo;
    exp_hi_last = 32'h0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== lo) begin
      errors++; $display("FAIL %s hold: valid=%b out=%h expected 0/%h", name, bus.out_valid, bus.out, lo);
    end
  endtask

  // One multiply; optionally tries an ADD issue while busy, which must be ignored.
  task automatic run_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit inject, input string name);
    int lat, busy_cycles, ready_low;
    bit got;
    lat = 0; busy_cycles = 0; ready_low = 0; got = 1'b0;
    @(negedge clk);
    drive_op(OP_MUL, sgn, a, b);
    for (int c = 1; c <= MUL_LAT + 20 && !got; c++) begin
      @(negedge clk);
      if (c == 1) drive_idle();
      if (inject && c == 5) drive_op(OP_ADD, 1'b0, 32'h1, 32'h1);
      if (inject && c == 6) drive_idle();
      if (c == 2) begin
        checks++;
        if (state_dbg !== ST_MUL) begin
          errors++; $display("FAIL %s state: got %0d expected %0d", name, state_dbg, ST_MUL);
        end
      end
      if (bus.out_valid === 1'b1) begin
        got = 1'b1;
        lat = c - 1;
      end else begin
        if (bus.busy === 1'b1)     busy_cycles++;
        if (bus.in_ready === 1'b0) ready_low++;
      end
    end
    checks++;
    if (!got || lat != MUL_LAT) begin
      errors++; $display("FAIL %s latency: got %0d (seen=%0b) expected %0d", name, lat, got, MUL_LAT);
    end
    checks++;
    if (busy_cycles != MUL_LAT || ready_low != MUL_LAT) begin
      errors++; $display("FAIL %s busy: busy=%0d ready_low=%0d expected %0d", name, busy_cycles, ready_low, MUL_LAT);
    end
    checks++;
    if (bus.out !== exp[31:0] || bus.out_hi !== exp[63:32]) begin
      errors++; $display("FAIL %s product: got %h_%h expected %h", name, bus.out_hi, bus.out, exp);
    end
    checks++;
    if (bus.zero !== (exp[31:0] == 32'h0)) begin
      errors++; $display("FAIL %s zero: got %b expected %b", name, bus.zero, exp[31:0] == 32'h0);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s release: busy=%b in_ready=%b expected 0/1", name, bus.busy, bus.in_ready);
    end
    exp_lo_last = exp[31:0];
    exp_hi_last = exp[63:32];
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== exp_lo_last) begin
      errors++; $display("FAIL %s after: valid=%b out=%h expected 0/%h", name, bus.out_valid, bus.out, exp_lo_last);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out !== 32'h0 || bus.out_hi !== 32'h0 || bus.zero !== 1'b0) begin
      errors++; $display("FAIL reset_data: out=%h out_hi=%h zero=%b expected 0", bus.out, bus.out_hi, bus.zero);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || state_dbg !== ST_IDLE) begin
      errors++; $display("FAIL reset_ctrl: valid=%b busy=%b ready=%b state=%0d expected 0/0/1/0",
                         bus.out_valid, bus.busy, bus.in_ready, state_dbg);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_cycle();
    logic [4:0]  ctl;
    logic        sgn;
    logic [31:0] a, b;
    run_single(OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'h1,         64'h0000_0000_8000_0000, "add_wrap_sign");
    run_single(OP_SUB, 1'b0, 32'h5,         32'h5,         64'h0,                   "sub_zero");
    run_single(OP_SLT, 1'b1, 32'hFFFF_FFFF, 32'h1,         64'h1,                   "slt_signed");
    run_single(OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'h1,         64'h0,                   "slt_unsigned");
    run_single(OP_SRA, 1'b0, 32'h4,         32'h8000_0000, 64'hF800_0000,           "sra");
    run_single(OP_SRL, 1'b1, 32'h4,         32'h8000_0000, 64'h0800_0000,           "srl");
    run_single(OP_SLL, 1'b0, 32'hFFFF_FFE4, 32'h1,         64'h10,                  "sll_upper_ignored");
    run_single(OP_NOR, 1'b0, 32'hF0F0_0000, 32'h0F0F_0000, 64'h0000_FFFF,           "nor");
    run_single(OP_SUB, 1'b0, 32'h0,         32'h1,         64'hFFFF_FFFF,           "sub_wrap");
    for (int i = 0; i < 12; i++) begin
      ctl = 5'($urandom_range(0, 31));
      if (ctl == OP_MUL) ctl = OP_AND;
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      run_single(ctl, sgn, a, b, model(ctl, sgn, a, b), "rand_single");
    end
  endtask

  task automatic test_mul();
    logic        sgn;
    logic [31:0] a, b;
    run_mul(1'b0, 32'hFFFF_FFFF, 32'h2,         64'h0000_0001_FFFF_FFFE, 1'b1, "mul_u_ignore_issue");
    run_mul(1'b1, 32'hFFFF_FFFD, 32'h7,         64'hFFFF_FFFF_FFFF_FFEB, 1'b0, "mul_s_neg");
    run_mul(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, "mul_s_minint");
    run_mul(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 1'b0, "mul_s_mixed");
    run_mul(1'b1, 32'hFFFF_FFFB, 32'h0,         64'h0,                   1'b0, "mul_s_zero");
    for (int i = 0; i < 4; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      run_mul(sgn, a, b, model(OP_MUL, sgn, a, b), 1'b0, "mul_rand");
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    logic [4:0]  ctl;
    logic        sgn;
    logic [31:0] a, b;
    exp_q.delete();
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== e[31:0] || bus.out_hi !== 32'h0 ||
            bus.zero !== (e[31:0] == 32'h0)) begin
          errors++; $display("FAIL b2b[%0d]: valid=%b out=%h hi=%h zero=%b expected 1/%h/0/%b",
                             i, bus.out_valid, bus.out, bus.out_hi, bus.zero, e[31:0], e[31:0] == 32'h0);
        end
        exp_lo_last = e[31:0];
        exp_hi_last = 32'h0;
      end
      if (i < 40) begin
        ctl = 5'($urandom_range(0, 31));
        if (ctl == OP_MUL) ctl = OP_XOR;
        sgn = 1'($urandom_range(0, 1));
        a   = $urandom;
        b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
        drive_op(ctl, sgn, a, b);
        exp_q.push_back(model(ctl, sgn, a, b));
      end else begin
        drive_idle();
      end
    end
  endtask

  task automatic test_flush_issue();
    @(negedge clk);
    drive_op(OP_ADD, 1'b0, 32'h10, 32'h20);
    bus.flush = 1'b1;
    @(negedge clk);
    drive_idle();
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== exp_lo_last) begin
      errors++; $display("FAIL flush_issue: valid=%b out=%h expected 0/%h", bus.out_valid, bus.out, exp_lo_last);
    end
  endtask

  task automatic test_flush_mid_mul();
    int seen;
    @(negedge clk);
    drive_op(OP_MUL, 1'b0, 32'h1234, 32'h5678);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) drive_idle();
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || state_dbg !== ST_IDLE) begin
      errors++; $display("FAIL flush_mul: busy=%b ready=%b valid=%b state=%0d expected 0/1/0/0",
                         bus.busy, bus.in_ready, bus.out_valid, state_dbg);
    end
    seen = 0;
    repeat (MUL_LAT + 5) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || bus.out !== exp_lo_last || bus.out_hi !== exp_hi_last) begin
      errors++; $display("FAIL flush_mul_quiet: pulses=%0d out=%h expected 0/%h", seen, bus.out, exp_lo_last);
    end
    run_single(OP_ADD, 1'b0, 32'h0000_0100, 32'h0000_0023, 64'h123, "add_after_flush");
  endtask

  task automatic test_flush_done();
    int seen;
    @(negedge clk);
    drive_op(OP_MUL, 1'b0, 32'h3, 32'h5);
    for (int c = 1; c <= MUL_LAT; c++) begin
      @(negedge clk);
      if (c == 1) drive_idle();
    end
    // The next edge is the one that would load the result.
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    seen = (bus.out_valid !== 1'b0) ? 1 : 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || bus.out !== exp_lo_last || bus.busy !== 1'b0) begin
      errors++; $display("FAIL flush_done: pulses=%0d out=%h busy=%b expected 0/%h/0",
                         seen, bus.out, bus.busy, exp_lo_last);
    end
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    run_mul(1'b0, 32'hFFFF_FFFF, 32'h3, 64'h0000_0002_FFFF_FFFD, 1'b0, "mul_pre_reset");
    @(negedge clk);
    drive_op(OP_MUL, 1'b1, 32'hFFFF_0000, 32'h1234_5678);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) drive_idle();
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out !== 32'h0 || bus.out_hi !== 32'h0 || bus.zero !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_mul: out=%h hi=%h zero=%b valid=%b busy=%b ready=%b expected 0/0/0/0/0/1",
                         bus.out, bus.out_hi, bus.zero, bus.out_valid, bus.busy, bus.in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_lo_last = 32'h0;
    exp_hi_last = 32'h0;
    seen = 0;
    repeat (MUL_LAT + 5) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_mid_mul_quiet: active cycles=%0d expected 0", seen);
    end
  endtask

  task automatic test_undefined();
    run_single(5'b01010, 1'b0, 32'h3, 32'h4, 64'h7, "undef_ctl");
    run_single(5'b00011, 1'b1, 32'hFFFF_FFFF, 32'h1, 64'h0, "undef_ctl_wrap");
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.ALUCtl   = 5'b0;
    bus.Sign     = 1'b0;
    bus.in1      = 32'h0;
    bus.in2      = 32'h0;
    reset_n      = 1'b0;
    test_reset();
    test_single_cycle();
    test_mul();
    test_back_to_back();
    test_flush_issue();
    test_flush_mid_mul();
    test_flush_done();
    test_reset_mid_mul();
    test_undefined();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
